// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_pe systolic processing element.
// Pure definitions: no logic, no latency, no backpressure.
package mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_K_MAX  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } mac_state_e;

    // Signed clamp limits for an acc_w-bit accumulator; callers keep the low acc_w bits.
    function automatic logic [63:0] sat_max(input int acc_w);
        sat_max = (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int acc_w);
        sat_min = ~sat_max(acc_w);
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Signed ACC_W adder with overflow flag; clamps on overflow when MAC_SATURATE_EN is defined.
// Combinational, zero latency; no handshake, so no backpressure.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] op_a,
    input  logic [ACC_W-1:0] op_b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] raw;

    assign raw = op_a + op_b;
    assign ovf = (op_a[ACC_W-1] == op_b[ACC_W-1]) && (raw[ACC_W-1] != op_a[ACC_W-1]);

`ifdef MAC_SATURATE_EN
    localparam logic [63:0]      MAX64   = sat_max(ACC_W);
    localparam logic [63:0]      MIN64   = sat_min(ACC_W);
    localparam logic [ACC_W-1:0] POS_LIM = MAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] NEG_LIM = MIN64[ACC_W-1:0];

    // On overflow both operands share a sign, which picks the rail.
    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = op_a[ACC_W-1] ? NEG_LIM : POS_LIM;
        end
    end
`else
    always_comb begin
        sum = raw;
    end
`endif

endmodule

// File: rtl/mac_pe.sv
// Signed MAC processing element: forwards A/B east/south and accumulates dot products (MAC_SATURATE_EN clamps).
// Pass-through latency 1 cycle; result latency 1 cycle after the last beat; no backpressure, accepts a beat every cycle.
module mac_pe
    import mac_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ACC_W  = DEF_ACC_W,
    parameter  int K_MAX  = DEF_K_MAX,
    localparam int CNT_W  = $clog2(K_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              last_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    output logic              last_out,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              overflow
);

    mac_state_e          state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   a_out_q, a_out_d;
    logic [DATA_W-1:0]   b_out_q, b_out_d;
    logic                valid_out_q, valid_out_d;
    logic                last_out_q, last_out_d;
    logic [ACC_W-1:0]    acc_out_q, acc_out_d;
    logic                acc_valid_q, acc_valid_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                overflow_q, overflow_d;

    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    add_a;
    logic [ACC_W-1:0]    sum;
    logic                add_ovf;
    logic                first_beat;
    logic [CNT_W-1:0]    cnt_next;
    logic                ovf_next;
    logic                final_beat;

    assign prod     = $signed(a_in) * $signed(b_in);
    assign prod_ext = ACC_W'(prod);

    // Any beat outside ACCUM opens a new dot product, which is what lets DONE take a zero-gap follow-on.
    assign first_beat = (state_q != ST_ACCUM);
    assign add_a      = first_beat ? '0 : acc_q;
    assign cnt_next   = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign ovf_next   = add_ovf | (~first_beat & ovf_q);
    assign final_beat = in_valid & (last_in | (cnt_next == CNT_W'(K_MAX)));

    mac_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .op_a (add_a),
        .op_b (prod_ext),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        valid_out_d = in_valid;
        last_out_d  = in_valid & last_in;
        acc_out_d   = acc_out_q;
        beat_cnt_d  = beat_cnt_q;
        overflow_d  = overflow_q;
        acc_valid_d = 1'b0;

        if (in_valid) begin
            a_out_d = a_in;
            b_out_d = b_in;
            acc_d   = sum;
            cnt_d   = cnt_next;
            ovf_d   = ovf_next;
        end

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (in_valid) begin
                    state_d = final_beat ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (in_valid) begin
                    state_d = final_beat ? ST_DONE : ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (final_beat) begin
            acc_out_d   = sum;
            beat_cnt_d  = cnt_next;
            overflow_d  = ovf_next;
            acc_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;
    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign beat_cnt  = beat_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe at DATA_W=8, ACC_W=16, K_MAX=4; expected results come from an integer reference model.
module tb_mac_pe;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int KM = 4;
    localparam int CW = $clog2(KM + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          last_in = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic [DW-1:0] a_out, b_out;
    logic          valid_out, last_out, acc_valid, overflow;
    logic [AW-1:0] acc_out;
    logic [CW-1:0] beat_cnt;

    mac_pe #(.DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .last_in   (last_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .beat_cnt  (beat_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int cnt;
        bit ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_acc    = 0;
    int   m_cnt    = 0;
    bit   m_ovf    = 1'b0;

    // Scoreboard: every acc_valid pulse must match the oldest modelled result.
    always @(negedge clk) begin
        exp_t          e;
        logic [AW-1:0] ea;
        if (!rst && acc_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: acc_valid with acc_out=%0d, no result was due", $signed(acc_out));
            end else begin
                e  = sb_q.pop_front();
                ea = e.acc[AW-1:0];
                if (acc_out !== ea) begin
                    failures++;
                    $display("FAIL sb_acc: got %0d want %0d", $signed(acc_out), e.acc);
                end
                checks++;
                if (beat_cnt !== CW'(e.cnt)) begin
                    failures++;
                    $display("FAIL sb_cnt: got %0d want %0d", beat_cnt, e.cnt);
                end
                checks++;
                if (overflow !== e.ovf) begin
                    failures++;
                    $display("FAIL sb_ovf: got %0b want %0b", overflow, e.ovf);
                end
            end
        end
    end

    // Drives one cycle of input (called at a negedge), updates the model, returns at the next negedge.
    task automatic beat(input int a, input int b, input bit v, input bit l);
        int   full;
        bit   ovf;
        exp_t e;
        logic signed [AW-1:0] wrapped;
        in_valid = v;
        last_in  = l;
        a_in     = a[DW-1:0];
        b_in     = b[DW-1:0];
        if (v) begin
            full = ((m_cnt == 0) ? 0 : m_acc) + a * b;
            ovf  = (full > 32767) || (full < -32768);
            if (ovf) begin
`ifdef MAC_SATURATE_EN
                full = (full > 0) ? 32767 : -32768;
`else
                wrapped = full[AW-1:0];
                full    = int'(wrapped);
`endif
            end
            m_ovf = ((m_cnt == 0) ? 1'b0 : m_ovf) | ovf;
            m_acc = full;
            m_cnt++;
            if (l || m_cnt == KM) begin
                e.acc = m_acc;
                e.cnt = m_cnt;
                e.ovf = m_ovf;
                sb_q.push_back(e);
                m_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        beat(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_out, b_out, valid_out, last_out, acc_out, acc_valid, beat_cnt, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: acc_out=%0d a_out=%0d valid_out=%0b acc_valid=%0b want all zero",
                     acc_out, a_out, valid_out, acc_valid);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        beat(1, 4, 1'b1, 1'b0);
        checks++;
        if (a_out !== 8'd1 || b_out !== 8'd4 || valid_out !== 1'b1 || last_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_passthru: a_out=%0d b_out=%0d v=%0b l=%0b want 1 4 1 0", a_out, b_out, valid_out, last_out);
        end
        beat(2, 5, 1'b1, 1'b0);
        checks++;
        if (acc_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: acc_valid=%0b want 0", acc_valid);
        end
        beat(3, 6, 1'b1, 1'b1);
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 16'd32 || beat_cnt !== 3'd3 || last_out !== 1'b1) begin
            failures++;
            $display("FAIL basic_result: acc_valid=%0b acc_out=%0d cnt=%0d last_out=%0b want 1 32 3 1",
                     acc_valid, acc_out, beat_cnt, last_out);
        end
        idle();
        checks++;
        if (acc_valid !== 1'b0 || acc_out !== 16'd32 || valid_out !== 1'b0 || a_out !== 8'd3) begin
            failures++;
            $display("FAIL basic_pulse_hold: acc_valid=%0b acc_out=%0d valid_out=%0b a_out=%0d want 0 32 0 3",
                     acc_valid, acc_out, valid_out, a_out);
        end
    endtask

    task automatic test_signed_extremes();
        beat(-128, -128, 1'b1, 1'b1);
        checks++;
        if (acc_valid !== 1'b1 || $signed(acc_out) !== 16384) begin
            failures++;
            $display("FAIL extremes_pos: acc_valid=%0b acc_out=%0d want 1 16384", acc_valid, $signed(acc_out));
        end
        beat(-128, 127, 1'b1, 1'b1);
        checks++;
        if (acc_valid !== 1'b1 || $signed(acc_out) !== -16256) begin
            failures++;
            $display("FAIL extremes_neg: acc_valid=%0b acc_out=%0d want 1 -16256", acc_valid, $signed(acc_out));
        end
        idle();
    endtask

    task automatic test_back_to_back();
        beat(2, 3, 1'b1, 1'b0);
        idle();
        checks++;
        if (a_out !== 8'd2 || b_out !== 8'd3 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL bubble_hold: a_out=%0d b_out=%0d valid_out=%0b want 2 3 0", a_out, b_out, valid_out);
        end
        idle();
        beat(4, 5, 1'b1, 1'b1);
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 16'd26 || beat_cnt !== 3'd2) begin
            failures++;
            $display("FAIL b2b_first: acc_valid=%0b acc_out=%0d cnt=%0d want 1 26 2", acc_valid, acc_out, beat_cnt);
        end
        beat(1, 1, 1'b1, 1'b1);
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 16'd1 || beat_cnt !== 3'd1) begin
            failures++;
            $display("FAIL b2b_second: acc_valid=%0b acc_out=%0d cnt=%0d want 1 1 1", acc_valid, acc_out, beat_cnt);
        end
        idle();
    endtask

    task automatic test_forced_last();
        repeat (4) beat(1, 1, 1'b1, 1'b0);
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 16'd4 || beat_cnt !== 3'd4) begin
            failures++;
            $display("FAIL forced_last: acc_valid=%0b acc_out=%0d cnt=%0d want 1 4 4", acc_valid, acc_out, beat_cnt);
        end
        beat(1, 1, 1'b1, 1'b0);
        checks++;
        if (acc_valid !== 1'b0) begin
            failures++;
            $display("FAIL forced_pending: acc_valid=%0b want 0", acc_valid);
        end
        beat(1, 1, 1'b1, 1'b1);
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 16'd2 || beat_cnt !== 3'd2) begin
            failures++;
            $display("FAIL forced_next: acc_valid=%0b acc_out=%0d cnt=%0d want 1 2 2", acc_valid, acc_out, beat_cnt);
        end
        idle();
    endtask

    task automatic test_overflow();
        int want;
`ifdef MAC_SATURATE_EN
        want = 32767;
`else
        want = -17149;
`endif
        beat(127, 127, 1'b1, 1'b0);
        beat(127, 127, 1'b1, 1'b0);
        beat(127, 127, 1'b1, 1'b1);
        checks++;
        if (acc_valid !== 1'b1 || overflow !== 1'b1 || $signed(acc_out) !== want) begin
            failures++;
            $display("FAIL overflow_set: acc_valid=%0b ovf=%0b acc_out=%0d want 1 1 %0d",
                     acc_valid, overflow, $signed(acc_out), want);
        end
        beat(1, 1, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0 || acc_out !== 16'd1) begin
            failures++;
            $display("FAIL overflow_clear: ovf=%0b acc_out=%0d want 0 1", overflow, acc_out);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        beat(5, 5, 1'b1, 1'b0);
        beat(5, 5, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        m_cnt    = 0;
        #1;
        checks++;
        if ({a_out, b_out, valid_out, last_out, acc_out, acc_valid, beat_cnt, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: acc_out=%0d a_out=%0d valid_out=%0b want all zero",
                     acc_out, a_out, valid_out);
        end
        @(negedge clk);
        checks++;
        if (acc_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_valid: acc_valid=%0b want 0", acc_valid);
        end
        rst = 1'b0;
        idle();
        beat(2, 2, 1'b1, 1'b1);
        checks++;
        if (acc_valid !== 1'b1 || acc_out !== 16'd4 || beat_cnt !== 3'd1) begin
            failures++;
            $display("FAIL reset_mid_after: acc_valid=%0b acc_out=%0d cnt=%0d want 1 4 1", acc_valid, acc_out, beat_cnt);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_extremes();
        test_back_to_back();
        test_forced_last();
        test_overflow();
        test_reset_mid();
        repeat (3) idle();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d results outstanding, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
